// File: rtl/ieeedrv_pkg.sv
// Shared IEEE drive definitions: track geometry and the track-buffer controller states.
package ieeedrv_pkg;

   localparam int TRK_MAX_4040 = 35;
   localparam int TRK_MAX_8250 = 154;

   typedef enum logic [2:0] {IDLE, CALC, FLUSH, FLUSH_WAIT, LOAD, LOAD_WAIT} trkbufState_t;

   // Highest sector number on a 1-based track; the 8250 zone layout repeats for the second side.
   function automatic logic [4:0] sector_max(input logic drv_type, input logic [7:0] track);
      logic [4:0] s;
      if (drv_type) begin
         if (track < 8'd18)       s = 5'd20;
         else if (track < 8'd25)  s = 5'd18;
         else if (track < 8'd31)  s = 5'd17;
         else                     s = 5'd16;
      end else if (track < 8'd78) begin
         if (track < 8'd40)       s = 5'd28;
         else if (track < 8'd54)  s = 5'd26;
         else if (track < 8'd65)  s = 5'd24;
         else                     s = 5'd22;
      end else begin
         if (track < 8'd117)      s = 5'd28;
         else if (track < 8'd131) s = 5'd26;
         else if (track < 8'd142) s = 5'd24;
         else                     s = 5'd22;
      end
      return s;
   endfunction

endpackage

// File: rtl/ieeedrv_trkofs.sv
// Iterative track offset: sums sectors of tracks 1..track-1, one track per clock.
module ieeedrv_trkofs
   import ieeedrv_pkg::*;
(
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        start,
   input  logic        drv_type,
   input  logic [7:0]  track,
   output logic        done,
   output logic [15:0] off
);

   logic [7:0] t;
   logic       run;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         t    <= '0;
         run  <= 1'b0;
         done <= 1'b0;
         off  <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            t   <= 8'd1;
            off <= '0;
            run <= 1'b1;
         end else if (run) begin
            if (t >= track) begin
               run  <= 1'b0;
               done <= 1'b1;
            end else begin
               off <= off + 16'(sector_max(drv_type, t)) + 16'd1;
               t   <= t + 8'd1;
            end
         end
      end
   end

endmodule

// File: rtl/ieeedrv_trkbuf_ctl.sv
// Track buffer controller: flushes a dirty track, then reads the newly selected track from SD.
module ieeedrv_trkbuf_ctl
   import ieeedrv_pkg::*;
#(
   parameter int SUBDRV = 2,
   parameter int MAXBLK = 16
)(
   input  logic                      clk_sys,
   input  logic                      reset,
   input  logic                      drv_type,
   input  logic [SUBDRV-1:0]         img_mounted,
   input  logic [SUBDRV-1:0]         img_size_ok,
   input  logic [$clog2(SUBDRV)-1:0] drv_act,
   input  logic [7:0]                track,
   input  logic                      buf_we,
   output logic                      loaded,
   output logic                      busy,
   output logic [31:0]               sd_lba,
   output logic [5:0]                sd_blk_cnt,
   output logic                      sd_sofs,
   output logic [SUBDRV-1:0]         sd_rd,
   output logic [SUBDRV-1:0]         sd_wr,
   input  logic [SUBDRV-1:0]         sd_ack
);

   trkbufState_t state, state_nx;

   logic [$clog2(SUBDRV)-1:0] cur_drv;
   logic [7:0]  cur_trk, trk_lim;
   logic        valid, dirty, flush_q, remount_q, ack_seen;
   logic        ofs_start, ofs_done;
   logic [15:0] ofs_off;
   logic [4:0]  sec_cur;
   logic [6:0]  blk_sum;
   logic [5:0]  blk_calc;
   logic        ack_cur, remount_any, mismatch, change, trk_ok, xfer_done;
   logic        idle_flush, idle_latch;

   assign ack_cur     = sd_ack[cur_drv];
   assign remount_any = remount_q | img_mounted[cur_drv];
   assign mismatch    = (cur_drv != drv_act) || (cur_trk != track);
   assign change      = mismatch || remount_any;
   assign trk_lim     = drv_type ? 8'(TRK_MAX_4040) : 8'(TRK_MAX_8250);
   assign trk_ok      = (cur_trk != 8'd0) && (cur_trk <= trk_lim);
   assign xfer_done   = ack_seen && !ack_cur;
   // A replaced image discards the buffer instead of writing it back.
   assign idle_flush  = (state == IDLE) && change && valid && dirty && !remount_any;
   assign idle_latch  = (state == IDLE) && change && !idle_flush;

   assign sec_cur = sector_max(drv_type, cur_trk);
   always_comb begin
      blk_sum  = 7'(ofs_off[0]) + 7'(sec_cur) + 7'd2;
      blk_calc = 6'(blk_sum >> 1) - 6'd1;
      if (blk_calc > 6'(MAXBLK - 1)) blk_calc = 6'(MAXBLK - 1);
   end

   ieeedrv_trkofs u_trkofs (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .start    (ofs_start),
      .drv_type (drv_type),
      .track    (cur_trk),
      .done     (ofs_done),
      .off      (ofs_off)
   );

   always_ff @(posedge clk_sys) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:       if (change) state_nx = CALC;
         CALC: begin
            if (flush_q) begin
               if (ofs_done) state_nx = FLUSH;
            end else if (!trk_ok) begin
               state_nx = IDLE;
            end else if (ofs_done) begin
               state_nx = img_size_ok[cur_drv] ? LOAD : IDLE;
            end
         end
         FLUSH:      state_nx = FLUSH_WAIT;
         FLUSH_WAIT: if (xfer_done) state_nx = IDLE;
         LOAD:       state_nx = LOAD_WAIT;
         LOAD_WAIT:  if (xfer_done) state_nx = IDLE;
         default:    state_nx = IDLE;
      endcase
   end

   always_comb begin
      sd_rd     = '0;
      sd_wr     = '0;
      busy      = (state != IDLE);
      ofs_start = (state == IDLE) && change;
      if (state == FLUSH || (state == FLUSH_WAIT && !ack_seen)) sd_wr[cur_drv] = 1'b1;
      if (state == LOAD  || (state == LOAD_WAIT  && !ack_seen)) sd_rd[cur_drv] = 1'b1;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         cur_drv    <= '0;
         cur_trk    <= '0;
         valid      <= 1'b0;
         dirty      <= 1'b0;
         flush_q    <= 1'b0;
         remount_q  <= 1'b0;
         ack_seen   <= 1'b0;
         loaded     <= 1'b0;
         sd_lba     <= '0;
         sd_blk_cnt <= '0;
         sd_sofs    <= 1'b0;
      end else begin
         loaded <= valid && (state == IDLE) && !mismatch && !remount_any;
         if (state == IDLE || state == CALC) ack_seen <= 1'b0;
         else if (ack_cur)                   ack_seen <= 1'b1;
         if (img_mounted[cur_drv]) remount_q <= 1'b1;
         // Order matters: a write strobe in the flush-completion cycle keeps the buffer dirty.
         if (state == FLUSH_WAIT && xfer_done) begin
            dirty   <= 1'b0;
            flush_q <= 1'b0;
         end
         if (buf_we && valid) dirty <= 1'b1;
         if (remount_any)     dirty <= 1'b0;
         if (idle_flush)      flush_q <= 1'b1;
         if (idle_latch) begin
            cur_drv   <= drv_act;
            cur_trk   <= track;
            valid     <= 1'b0;
            dirty     <= 1'b0;
            flush_q   <= 1'b0;
            remount_q <= 1'b0;
         end
         if (state == LOAD_WAIT && xfer_done) valid <= 1'b1;
         if (state == CALC && ofs_done && (flush_q || trk_ok)) begin
            sd_lba     <= {17'd0, ofs_off[15:1]};
            sd_sofs    <= ofs_off[0];
            sd_blk_cnt <= blk_calc;
         end
      end
   end

endmodule
